// File: rtl/xbus_master.sv
// xbus_master: single-master Xbus sequencer; broadcasts one CPU request, selects the
// decoding slave, returns its data, and flags no-decode/timeout errors.
module xbus_master #(
    parameter int NSLAVE  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_write,
    input  logic [21:0]          cpu_addr,
    input  logic [31:0]          cpu_datain,
    output logic [31:0]          cpu_dataout,
    output logic                 cpu_ack,
    output logic                 cpu_err,
    output logic                 xbus_req,
    output logic                 xbus_write,
    output logic [21:0]          xbus_addr,
    output logic [31:0]          xbus_dataout,
    input  logic [NSLAVE-1:0]    slv_decode,
    input  logic [NSLAVE-1:0]    slv_ack,
    input  logic [32*NSLAVE-1:0] slv_datain,
    output logic [NSLAVE-1:0]    sel,
    output logic                 nxm,
    output logic                 conflict
);
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_DONE, S_ERR, S_RECOVER} state_t;
    state_t            r_state, w_state;
    logic [7:0]        r_cnt, w_cnt_inc;
    logic [NSLAVE-1:0] r_sel, w_first;
    logic              r_nxm, r_conflict, r_write, w_ack_sel, w_expired;
    logic [21:0]       r_addr;
    logic [31:0]       r_wdata, r_dataout, w_rdata;

    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_expired = (w_cnt_inc == 8'(TIMEOUT));
    assign w_first   = slv_decode & (~slv_decode + NSLAVE'(1));
    assign w_ack_sel = |(slv_ack & r_sel);

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NSLAVE; i++)
            w_rdata = w_rdata | (r_sel[i] ? slv_datain[32*i +: 32] : 32'd0);
    end

    always_comb begin
        w_state  = r_state;
        xbus_req = (r_state == S_DECODE) || (r_state == S_WAIT);
        cpu_ack  = (r_state == S_DONE) || (r_state == S_ERR);
        cpu_err  = (r_state == S_ERR);
        case (r_state)
            S_IDLE:    w_state = cpu_req ? S_DECODE : S_IDLE;
            S_DECODE:  w_state = (|slv_decode) ? S_WAIT : S_ERR;
            S_WAIT:    w_state = w_ack_sel ? S_DONE : (w_expired ? S_ERR : S_WAIT);
            S_DONE:    w_state = S_RECOVER;
            S_ERR:     w_state = S_RECOVER;
            S_RECOVER: w_state = (!(|slv_ack) || w_expired) ? S_IDLE : S_RECOVER;
            default:   w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_nxm      <= 1'b0;
            r_conflict <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dataout  <= '0;
        end else begin
            r_state <= w_state;
            if (r_state == S_IDLE && cpu_req) begin
                r_write <= cpu_write;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_datain;
            end
            // The counter times WAIT and, restarted from 0, bounds the RECOVER drain
            if (r_state == S_DECODE) begin
                r_sel <= w_first;
                r_cnt <= '0;
                if (!(|slv_decode)) r_nxm <= 1'b1;
                if (|(slv_decode & (slv_decode - NSLAVE'(1)))) r_conflict <= 1'b1;
            end else if (r_state == S_WAIT || r_state == S_RECOVER) begin
                r_cnt <= w_cnt_inc;
            end else begin
                r_cnt <= '0;
            end
            if (r_state == S_WAIT && w_ack_sel)
                r_dataout <= r_write ? 32'd0 : w_rdata;
            else if (w_state == S_ERR)
                r_dataout <= '0;
        end
    end

    assign cpu_dataout  = r_dataout;
    assign xbus_write   = r_write;
    assign xbus_addr    = r_addr;
    assign xbus_dataout = r_wdata;
    assign sel          = r_sel;
    assign nxm          = r_nxm;
    assign conflict     = r_conflict;
endmodule

// File: tb/tb_xbus_master.sv
// tb_xbus_master: directed cycle-by-cycle bench for xbus_master; cycle 0 is the
// IDLE cycle in which cpu_req is first sampled.
module tb_xbus_master;
    logic         clk = 1'b0;
    logic         reset, cpu_req, cpu_write;
    logic [21:0]  cpu_addr;
    logic [31:0]  cpu_datain, cpu_dataout, xbus_dataout;
    logic         cpu_ack, cpu_err, xbus_req, xbus_write, nxm, conflict;
    logic [21:0]  xbus_addr;
    logic [3:0]   slv_decode, slv_ack, sel;
    logic [127:0] slv_datain;
    int           n_chk = 0;
    int           n_fail = 0;

    xbus_master #(.NSLAVE(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_datain(cpu_datain), .cpu_dataout(cpu_dataout),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .xbus_req(xbus_req),
        .xbus_write(xbus_write), .xbus_addr(xbus_addr), .xbus_dataout(xbus_dataout),
        .slv_decode(slv_decode), .slv_ack(slv_ack), .slv_datain(slv_datain),
        .sel(sel), .nxm(nxm), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, " ack"}, cpu_ack, 0);
        chk({tag, " err"}, cpu_err, 0);
        chk({tag, " req"}, xbus_req, 0);
        chk({tag, " dout"}, cpu_dataout, 0);
        chk({tag, " addr"}, xbus_addr, 0);
        chk({tag, " wr"}, xbus_write, 0);
        chk({tag, " wdata"}, xbus_dataout, 0);
        chk({tag, " sel"}, sel, 0);
        chk({tag, " nxm"}, nxm, 0);
        chk({tag, " conflict"}, conflict, 0);
    endtask

    initial begin
        reset = 1; cpu_req = 0; cpu_write = 0; cpu_addr = '0; cpu_datain = '0;
        slv_decode = '0; slv_ack = '0; slv_datain = '0;
        step(); step();
        reset = 0;
        chk_idle_outs("reset");

        // Read from Unibus slave 3, ack 2 cycles into WAIT, lingering 2 cycles after req drops
        cpu_req = 1; cpu_write = 0; cpu_addr = 22'o17773005; cpu_datain = 32'hDEADBEEF;
        slv_datain = {32'h0, 32'h22222222, 32'h11111111, 32'h33333333};
        step();
        chk("rd1 req c1", xbus_req, 1);
        chk("rd1 addr", xbus_addr, 22'o17773005);
        slv_decode = 4'b1000;
        step();
        chk("rd1 sel", sel, 4'b1000);
        chk("rd1 conflict", conflict, 0);
        step();
        chk("rd1 noack c3", cpu_ack, 0);
        step();
        slv_ack = 4'b1000;
        chk("rd1 noack c4", cpu_ack, 0);
        step();
        chk("rd1 ack c5", cpu_ack, 1);
        chk("rd1 err", cpu_err, 0);
        chk("rd1 dout", cpu_dataout, 0);
        chk("rd1 req drop", xbus_req, 0);
        cpu_req = 0; slv_decode = 0;
        step();
        chk("rd1 single ack", cpu_ack, 0);
        step();
        slv_ack = 0;
        step();
        step();

        // Write to slave 3; CPU keeps req high while the ack drains
        cpu_req = 1; cpu_write = 1; cpu_addr = 22'o17773020; cpu_datain = 32'o44;
        slv_datain = {32'hFFFFFFFF, 96'h0};
        step();
        slv_decode = 4'b1000;
        for (int c = 1; c <= 4; c++) begin
            chk("wr write", xbus_write, 1);
            chk("wr wdata", xbus_dataout, 32'o44);
            chk("wr req", xbus_req, 1);
            if (c == 4) slv_ack = 4'b1000;
            step();
        end
        chk("wr ack", cpu_ack, 1);
        chk("wr err", cpu_err, 0);
        chk("wr dout zero", cpu_dataout, 0);
        slv_decode = 0;
        for (int c = 6; c <= 10; c++) begin
            if (c == 8) begin slv_ack = 0; cpu_req = 0; end
            step();
            chk("wr no retrigger req", xbus_req, 0);
            chk("wr no retrigger ack", cpu_ack, 0);
            if (c <= 8) chk("wr wdata hold", xbus_dataout, 32'o44);
        end

        // Slaves 0 and 2 decode; slave 2's ack must be ignored
        cpu_req = 1; cpu_write = 0; cpu_addr = 22'o100;
        slv_datain = {32'h0, 32'h00000BAD, 32'h0, 32'h12345678};
        step();
        slv_decode = 4'b0101;
        step();
        chk("cf sel", sel, 4'b0001);
        chk("cf conflict", conflict, 1);
        slv_ack = 4'b0100;
        step();
        chk("cf ignore ack2", cpu_ack, 0);
        chk("cf req held", xbus_req, 1);
        slv_ack = 4'b0001;
        step();
        chk("cf ack", cpu_ack, 1);
        chk("cf dout", cpu_dataout, 32'h12345678);
        cpu_req = 0; slv_ack = 0; slv_decode = 0;
        step(); step();

        // Slave 1 decodes but never acks: 16 WAIT cycles then error
        cpu_req = 1; cpu_addr = 22'o2000;
        step();
        slv_decode = 4'b0010;
        step();
        for (int c = 2; c <= 17; c++) begin
            chk("to wait req", xbus_req, 1);
            chk("to wait ack", cpu_ack, 0);
            step();
        end
        chk("to ack", cpu_ack, 1);
        chk("to err", cpu_err, 1);
        chk("to req drop", xbus_req, 0);
        chk("to dout", cpu_dataout, 0);
        chk("to nxm", nxm, 0);
        cpu_req = 0; slv_decode = 0;
        step(); step();

        // No slave decodes
        cpu_req = 1; cpu_addr = 22'o00001000;
        step();
        chk("nx req", xbus_req, 1);
        step();
        chk("nx ack", cpu_ack, 1);
        chk("nx err", cpu_err, 1);
        chk("nx dout", cpu_dataout, 0);
        chk("nx nxm", nxm, 1);
        cpu_req = 0;
        step();
        chk("nx single ack", cpu_ack, 0);
        step(); step();
        chk("nx nxm sticky", nxm, 1);
        chk("cf conflict sticky", conflict, 1);

        // Reset in WAIT with ack pending, then a normal transaction
        cpu_req = 1; cpu_addr = 22'o300;
        step();
        slv_decode = 4'b1000;
        step();
        slv_ack = 4'b1000; reset = 1;
        step();
        reset = 0;
        chk_idle_outs("rst mid");
        slv_decode = 0;
        step();
        slv_ack = 0; slv_decode = 4'b1000;
        slv_datain = {32'hCAFEF00D, 96'h0};
        chk("post rst req", xbus_req, 1);
        step();
        slv_ack = 4'b1000;
        step();
        chk("post rst ack", cpu_ack, 1);
        chk("post rst err", cpu_err, 0);
        chk("post rst dout", cpu_dataout, 32'hCAFEF00D);
        cpu_req = 0; slv_ack = 0; slv_decode = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
